// File: rtl/vsbg_pkg.sv
// Shared types and helpers for the variable-precision stochastic bitstream generator.
package vsbg_pkg;

  // Natural operand width; bitrev below is sized to it.
  localparam int VSBG_W = 8;

  // Width of a field able to hold 0..w inclusive.
  function automatic int prec_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Generator control states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bit-reverse a VSBG_W-bit value: the van der Corput ordering of a counter.
  function automatic logic [VSBG_W-1:0] bitrev(input logic [VSBG_W-1:0] v);
    logic [VSBG_W-1:0] r;
    for (int i = 0; i < VSBG_W; i++) begin
      r[VSBG_W-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/vsbg_vdc_counter.sv
// W+1-bit beat counter with clear/enable that also exposes its bit-reversed
// low W bits, the van der Corput threshold sequence.
module vdc_counter
  import vsbg_pkg::*;
#(
  parameter int W = VSBG_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W:0]   cnt,
  output logic [W-1:0] rev
);

  logic [W:0] cnt_q;
  logic [W:0] cnt_d;

  // Clear wins over increment so a new stream always starts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + (W+1)'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

  // Reversal of the low W bits; the package helper covers the native width.
  generate
    if (W == VSBG_W) begin : g_pkg_rev
      assign rev = bitrev(cnt_q[W-1:0]);
    end else begin : g_loop_rev
      // Generic reversal for non-native widths.
      always_comb begin
        rev = '0;
        for (int i = 0; i < W; i++) begin
          rev[i] = cnt_q[W-1-i];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/vsbg.sv
// Variable-precision stochastic bitstream generator: turns a W-bit operand
// into a unipolar stream whose every 2^k-beat prefix carries the k-bit value.
module vsbg
  import vsbg_pkg::*;
#(
  parameter int W  = VSBG_W,
  parameter int PW = prec_width(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x_in,
  input  logic [PW-1:0] prec_in,
  input  logic          rshift,
  input  logic          term,
  output logic          z,
  output logic          z_valid,
  input  logic          z_ready,
  output logic          z_last,
  output logic          busy
);

  state_e        state_q;
  state_e        state_d;
  logic [W-1:0]  x_q;
  logic [W-1:0]  x_d;
  logic [PW-1:0] p_q;
  logic [PW-1:0] p_d;
  logic [PW-1:0] p_eff;
  logic [PW-1:0] prec_clamped;
  logic [W:0]    limit;
  logic [W:0]    cnt;
  logic [W-1:0]  cnt_rev;
  logic          cnt_clr;
  logic          cnt_en;

  // Beat counter and its van der Corput threshold.
  vdc_counter #(
    .W(W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (cnt),
    .rev (cnt_rev)
  );

  // Effective precision this cycle (rshift never goes below zero) and the
  // last-beat index it implies; the input precision is clamped to W.
  always_comb begin
    prec_clamped = (prec_in > PW'(W)) ? PW'(W) : prec_in;
    p_eff        = (rshift && (p_q != '0)) ? (p_q - PW'(1)) : p_q;
    limit        = ((W+1)'(1) << p_eff) - (W+1)'(1);
  end

  // FSM next-state and outputs; outputs are combinational from registers so a
  // same-cycle rshift or term can make the current beat the last one.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    p_d      = p_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    z_valid  = 1'b0;
    z        = 1'b0;
    z_last   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = x_in;
          p_d     = prec_clamped;
          cnt_clr = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        z_valid = 1'b1;
        z       = (cnt_rev < x_q);
        z_last  = term || (cnt >= limit);
        p_d     = p_eff;
        if (z_ready) begin
          if (z_last) begin
            state_d = IDLE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand and precision registers; reset aborts any stream at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      p_q     <= p_d;
    end
  end

endmodule
